fregs_dump_streamer: RTL and testbench

Debug reader for the floating-point register file. On a start pulse it walks the file's display read port across all 32 registers and streams a framed byte image through a valid/ready byte interface, typically into the UART transmitter. It sits beside the register file, owning the display-select input, and never touches the write port.

---
 rtl/fregs_dump_streamer_pkg.sv | 20 ++
 rtl/fregs_dump_streamer.sv | 112 +++++++++++
 tb/tb_fregs_dump_streamer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fregs_dump_streamer_pkg.sv
// Shared definitions for the floating-point register file dump streamer.
package fregs_dump_streamer_pkg;

    // Frame walker states
    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StLoad,
        StData,
        StCsum
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Bytes in one frame: sync byte, four bytes per register, checksum byte
    function automatic int unsigned frame_len(input int unsigned num_regs);
        return 2 + 4 * num_regs;
    endfunction

endpackage

// File: rtl/fregs_dump_streamer.sv
// Walks the FP register file display port and streams a framed byte image:
// sync byte, each register MSB first, then an XOR checksum of the data bytes.
module fregs_dump_streamer
    import fregs_dump_streamer_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int unsigned NUM_REGS  = 32
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    output logic        oBusy,
    output logic [4:0]  oRegDispSelect,
    input  logic [31:0] iRegDisp,
    output logic [7:0]  oByte,
    output logic        oByteValid,
    input  logic        iByteReady,
    output logic        oDone
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t      state;
    logic [4:0]  idx;
    logic [1:0]  count;
    logic [7:0]  csum;
    // Only the three bytes still to be sent; the top byte goes straight to oByte
    logic [23:0] word;
    logic        xfer;

    assign xfer           = oByteValid & iByteReady;
    assign oRegDispSelect = idx;

    // Frame sequencing with registered stream, busy and done outputs
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state      <= StIdle;
            idx        <= 5'd0;
            count      <= 2'd0;
            csum       <= 8'd0;
            word       <= 24'd0;
            oBusy      <= 1'b0;
            oByte      <= 8'd0;
            oByteValid <= 1'b0;
            oDone      <= 1'b0;
        end else begin
            oDone <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (iStart) begin
                        state      <= StSync;
                        idx        <= 5'd0;
                        csum       <= 8'd0;
                        oBusy      <= 1'b1;
                        oByte      <= SYNC_BYTE;
                        oByteValid <= 1'b1;
                    end
                end
                StSync: begin
                    if (xfer) begin
                        state      <= StLoad;
                        oByteValid <= 1'b0;
                    end
                end
                StLoad: begin
                    // Snapshot the selected register; its MSB is presented immediately
                    word       <= iRegDisp[23:0];
                    oByte      <= iRegDisp[31:24];
                    oByteValid <= 1'b1;
                    count      <= 2'd0;
                    state      <= StData;
                end
                StData: begin
                    if (xfer) begin
                        csum  <= csum ^ oByte;
                        word  <= word << 8;
                        count <= count + 2'd1;
                        if (count == 2'd3) begin
                            if (idx == LAST_IDX) begin
                                // Checksum must include the byte transferring now
                                state <= StCsum;
                                oByte <= csum ^ oByte;
                            end else begin
                                state      <= StLoad;
                                idx        <= idx + 5'd1;
                                oByteValid <= 1'b0;
                            end
                        end else begin
                            oByte <= word[23:16];
                        end
                    end
                end
                StCsum: begin
                    if (xfer) begin
                        state      <= StIdle;
                        idx        <= 5'd0;
                        oBusy      <= 1'b0;
                        oByte      <= 8'd0;
                        oByteValid <= 1'b0;
                        oDone      <= 1'b1;
                    end
                end
                default: begin
                    state      <= StIdle;
                    oBusy      <= 1'b0;
                    oByteValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fregs_dump_streamer.sv
// Directed bench for fregs_dump_streamer: drives a register file model and
// compares the streamed frame against hand-computed and model bytes.
module tb_fregs_dump_streamer;
    import fregs_dump_streamer_pkg::*;

    localparam int LIMIT = 1000;

    logic        iCLK;
    logic        iRST;
    logic        iStart;
    logic        oBusy;
    logic [4:0]  oRegDispSelect;
    logic [31:0] iRegDisp;
    logic [7:0]  oByte;
    logic        oByteValid;
    logic        iByteReady;
    logic        oDone;

    logic [31:0] regs [32];
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];
    logic [4:0]  sel [$];

    int n_checks = 0;
    int n_errors = 0;

    fregs_dump_streamer dut (
        .iCLK           (iCLK),
        .iRST           (iRST),
        .iStart         (iStart),
        .oBusy          (oBusy),
        .oRegDispSelect (oRegDispSelect),
        .iRegDisp       (iRegDisp),
        .oByte          (oByte),
        .oByteValid     (oByteValid),
        .iByteReady     (iByteReady),
        .oDone          (oDone)
    );

    assign iRegDisp = regs[oRegDispSelect];

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 8'hxx;
    endfunction

    // Reference frame built from the register model
    task automatic build_exp();
        logic [7:0] cs;
        logic [31:0] w;
        cs = 8'd0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int r = 0; r < 32; r++) begin
            w = regs[r];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[31:24]);
                cs = cs ^ w[31:24];
                w = w << 8;
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic compare_frame(input string name);
        build_exp();
        check({name, " length"}, 32'(got.size()), 32'(frame_len(32)));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s byte%0d", name, i), 32'(got_at(i)), 32'(exp_q[i]));
    endtask

    // One frame; k counts cycles after the iStart sampling edge
    task automatic run_frame(input bit rand_ready, input bit chain_next, input bit prestarted,
                             output int done_k, output int lowcnt);
        bit         busy_ok;
        bit         prev_stall;
        logic [7:0] prev_byte;
        got.delete();
        sel.delete();
        if (!prestarted) begin
            @(negedge iCLK);
            iStart     = 1'b1;
            iByteReady = 1'b1;
        end
        done_k     = -1;
        lowcnt     = 0;
        busy_ok    = 1'b1;
        prev_stall = 1'b0;
        prev_byte  = 8'd0;
        for (int k = 1; k <= LIMIT && done_k < 0; k++) begin
            @(negedge iCLK);
            iStart     = (k == 60);
            iByteReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) begin
                check("hold valid", 32'(oByteValid), 32'd1);
                check("hold byte", 32'(oByte), 32'(prev_byte));
            end
            if (oDone) begin
                done_k = k;
                check("busy low at done", 32'(oBusy), 32'd0);
                if (chain_next) iStart = 1'b1;
            end else begin
                if (!oBusy) busy_ok = 1'b0;
                if (oByteValid && iByteReady) got.push_back(oByte);
                if (oByteValid && !iByteReady) lowcnt++;
                if (!oByteValid) sel.push_back(oRegDispSelect);
            end
            prev_stall = oByteValid && !iByteReady;
            prev_byte  = oByte;
        end
        check("busy through frame", 32'(busy_ok), 32'd1);
        check("done seen", 32'(done_k >= 0), 32'd1);
    endtask

    task automatic check_idle_after(input string name);
        @(negedge iCLK);
        iStart     = 1'b0;
        iByteReady = 1'b1;
        #1;
        check({name, " done one cycle"}, 32'(oDone), 32'd0);
        check({name, " idle valid"}, 32'(oByteValid), 32'd0);
    endtask

    initial begin
        int dk;
        int lc;
        int cnt;
        iRST       = 1'b1;
        iStart     = 1'b0;
        iByteReady = 1'b1;
        for (int r = 0; r < 32; r++) regs[r] = 32'd0;
        repeat (3) @(negedge iCLK);
        #1;
        check("rst busy", 32'(oBusy), 32'd0);
        check("rst valid", 32'(oByteValid), 32'd0);
        check("rst byte", 32'(oByte), 32'd0);
        check("rst sel", 32'(oRegDispSelect), 32'd0);
        check("rst done", 32'(oDone), 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;

        // All registers zero
        run_frame(1'b0, 1'b0, 1'b0, dk, lc);
        compare_frame("zero");
        check("zero sync", 32'(got_at(0)), 32'hA5);
        check("zero csum", 32'(got_at(129)), 32'h00);
        check("zero done cycle", 32'(dk), 32'd163);
        check_idle_after("zero");

        // Single non-zero register
        regs[1] = 32'h12345678;
        run_frame(1'b0, 1'b0, 1'b0, dk, lc);
        compare_frame("reg1");
        check("reg1 b5", 32'(got_at(5)), 32'h12);
        check("reg1 b6", 32'(got_at(6)), 32'h34);
        check("reg1 b7", 32'(got_at(7)), 32'h56);
        check("reg1 b8", 32'(got_at(8)), 32'h78);
        check("reg1 csum", 32'(got_at(129)), 32'h08);
        check("reg1 done cycle", 32'(dk), 32'd163);
        check_idle_after("reg1");

        // Reg k = 0x01010101*k, restarted in the oDone cycle
        for (int r = 0; r < 32; r++) regs[r] = 32'h01010101 * r;
        run_frame(1'b0, 1'b1, 1'b0, dk, lc);
        compare_frame("ramp");
        check("ramp b9", 32'(got_at(9)), 32'h02);
        check("ramp csum", 32'(got_at(129)), 32'h00);
        check("ramp sel count", 32'(sel.size()), 32'd32);
        for (int i = 0; i < 32; i++)
            check($sformatf("ramp sel%0d", i), 32'(i < sel.size() ? sel[i] : 5'bx), 32'(i));

        // Chained frame under random back-pressure
        run_frame(1'b1, 1'b0, 1'b1, dk, lc);
        compare_frame("bp");
        check("bp csum", 32'(got_at(129)), 32'h00);
        check("bp done cycle", 32'(dk), 32'(163 + lc));
        check_idle_after("bp");

        // Asynchronous reset while byte 40 is on the bus
        regs[1] = 32'h12345678;
        for (int r = 2; r < 32; r++) regs[r] = 32'd0;
        regs[0] = 32'd0;
        @(negedge iCLK);
        iStart = 1'b1;
        cnt = 0;
        for (int k = 0; k < LIMIT && cnt < 40; k++) begin
            @(negedge iCLK);
            iStart = 1'b0;
            #1;
            if (oByteValid && iByteReady) cnt++;
        end
        check("abort reached byte 40", 32'(cnt), 32'd40);
        #2;
        iRST = 1'b1;
        #1;
        check("abort busy", 32'(oBusy), 32'd0);
        check("abort valid", 32'(oByteValid), 32'd0);
        check("abort byte", 32'(oByte), 32'd0);
        check("abort sel", 32'(oRegDispSelect), 32'd0);
        check("abort done", 32'(oDone), 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        #1;
        check("post abort done", 32'(oDone), 32'd0);
        run_frame(1'b0, 1'b0, 1'b0, dk, lc);
        compare_frame("after rst");
        check("after rst csum", 32'(got_at(129)), 32'h08);
        check("after rst done cycle", 32'(dk), 32'd163);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
